// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// State codes are plain 2-bit constants so that legacy code can compare against them.
package fetch_pkg;

    localparam logic [1:0] FETCH_REQ  = 2'd0;
    localparam logic [1:0] FETCH_WAIT = 2'd1;
    localparam logic [1:0] FETCH_HOLD = 2'd2;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_TRAP = 2'd1,
        REDIR_EX   = 2'd2,
        REDIR_BP   = 2'd3
    } redir_src_e;

endpackage

// File: rtl/redirect_prio_mux.sv
// Fixed-priority selector for PC redirects: trap, then execute mispredict, then branch prediction.
import fetch_pkg::*;

module redirect_prio_mux #(
    parameter int PC_W = 64
) (
    input  logic            trap_valid,
    input  logic [PC_W-1:0] trap_pc,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            bp_valid,
    input  logic [PC_W-1:0] bp_pc,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output redir_src_e      redirect_src
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        redirect_src   = REDIR_NONE;
        if (trap_valid) begin
            redirect_valid = 1'b1;
            redirect_pc    = trap_pc;
            redirect_src   = REDIR_TRAP;
        end else if (ex_valid) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_pc;
            redirect_src   = REDIR_EX;
        end else if (bp_valid) begin
            redirect_valid = 1'b1;
            redirect_pc    = bp_pc;
            redirect_src   = REDIR_BP;
        end
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch PC sequencer: one outstanding imem request, redirect/kill handling, valid/ready to decode.
// Optional macro FETCH_PERF_EN adds saturating kill and stall counters.
import fetch_pkg::*;

module fetch_seq_ctrl #(
    parameter int              PC_W      = 64,
    parameter int              ILEN      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(64'h0000_0000_8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_valid,
    input  logic [PC_W-1:0] trap_pc,
    input  logic            ex_redirect_valid,
    input  logic [PC_W-1:0] ex_redirect_pc,
    input  logic            bp_taken,
    input  logic [PC_W-1:0] bp_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [ILEN-1:0] fetch_instr,
    output logic [PC_W-1:0] fetch_pc,
    output logic [PC_W-1:0] pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_kill_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    logic [1:0]      state;
    logic            kill;
    logic [PC_W-1:0] req_pc;

    logic            handshake;
    logic            redir_valid;
    logic [PC_W-1:0] redir_pc;
    redir_src_e      redir_src;
    logic            flush;
    logic            resp_drop;

    // The prediction only counts when decode actually takes the instruction.
    assign handshake = (state == FETCH_HOLD) && fetch_ready;

    redirect_prio_mux #(.PC_W(PC_W)) u_prio (
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .ex_valid       (ex_redirect_valid),
        .ex_pc          (ex_redirect_pc),
        .bp_valid       (handshake && bp_taken),
        .bp_pc          (bp_pc),
        .redirect_valid (redir_valid),
        .redirect_pc    (redir_pc),
        .redirect_src   (redir_src)
    );

    // A taken prediction is a normal sequencing step; only trap/mispredict squash work in flight.
    assign flush     = redir_valid && (redir_src != REDIR_BP);
    assign resp_drop = (state == FETCH_WAIT) && imem_resp_valid && (kill || flush);

    assign imem_req_valid = rst && (state == FETCH_REQ) && !flush;
    assign imem_req_addr  = pc;
    assign fetch_valid    = (state == FETCH_HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_VEC;
            state       <= FETCH_REQ;
            kill        <= 1'b0;
            req_pc      <= '0;
            fetch_instr <= '0;
            fetch_pc    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            if (redir_valid)
                pc <= redir_pc;
            else if (handshake)
                pc <= fetch_pc + PC_W'(INSTR_BYTES);

            case (state)
                FETCH_REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        req_pc <= pc;
                        state  <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (resp_drop) begin
                        kill  <= 1'b0;
                        state <= FETCH_REQ;
                    end else if (imem_resp_valid) begin
                        fetch_instr <= imem_resp_data;
                        fetch_pc    <= req_pc;
                        state       <= FETCH_HOLD;
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (flush || fetch_ready)
                        state <= FETCH_REQ;
                end
                default: state <= FETCH_REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_kill_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (resp_drop && (perf_kill_cnt != '1))
                perf_kill_cnt <= perf_kill_cnt + 32'd1;
            if ((state == FETCH_HOLD) && !fetch_ready && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
